// File: rtl/tpu_pkg.sv
// tpu_pkg: shared dimensions, opcodes and instruction layout for mini_tpu
package tpu_pkg;
  localparam int DIM = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W = 16;
  localparam int RUN_STEPS = 10;
  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_RUN   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_STORE = 2'b11
  } op_t;
  // Field positions: [15] reserved, [14:13] op, [12] sel, [11:10] row, [9:8] col, [7:0] data
  typedef struct packed {
    logic              rsvd;
    op_t               op;
    logic              sel;
    logic [1:0]        row;
    logic [1:0]        col;
    logic [DATA_W-1:0] data;
  } instr_t;
endpackage

// File: rtl/tpu_pe.sv
// tpu_pe: one systolic multiply-accumulate cell forwarding a right and b down
module tpu_pe
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [ACC_W-1:0]  acc
);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (en) begin
      acc   <= acc + {8'b0, a_in} * {8'b0, b_in};
      a_out <= a_in;
      b_out <= b_in;
    end
  end
endmodule

// File: rtl/mini_tpu.sv
// mini_tpu: 4x4 output-stationary systolic matmul driven by 16-bit instructions.
// Define TPU_SATURATE_EN to clamp STORE output to 8'hFF when acc > 255.
module mini_tpu
  import tpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  output logic [7:0]  result
);
  instr_t ins;
  logic [DATA_W-1:0] a_mem [DIM][DIM];
  logic [DATA_W-1:0] b_mem [DIM][DIM];
  logic [DATA_W-1:0] a_edge [DIM];
  logic [DATA_W-1:0] b_edge [DIM];
  logic [DATA_W-1:0] a_h [DIM][DIM+1];
  logic [DATA_W-1:0] b_v [DIM+1][DIM];
  logic [ACC_W-1:0]  acc [DIM][DIM];
  logic [ACC_W-1:0]  sel_acc;
  logic [7:0]        store_byte;
  logic [3:0]        step;
  logic              is_load, is_run;

  assign ins     = instr_t'(instruction);
  assign is_load = ins.op == OP_LOAD;
  assign is_run  = ins.op == OP_RUN;
  assign sel_acc = acc[ins.row][ins.col];

`ifdef TPU_SATURATE_EN
  assign store_byte = (sel_acc > 16'd255) ? 8'hFF : sel_acc[7:0];
`else
  assign store_byte = sel_acc[7:0];
`endif

  // Skewed feed: row i sees A[i][s-i], column j sees B[s-j][j], zero outside 0..3
  always_comb begin
    for (int i = 0; i < DIM; i++) begin
      a_edge[i] = (step >= 4'(i) && (step - 4'(i)) <= 4'd3) ? a_mem[i][2'(step - 4'(i))] : '0;
      b_edge[i] = (step >= 4'(i) && (step - 4'(i)) <= 4'd3) ? b_mem[2'(step - 4'(i))][i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          a_mem[i][j] <= '0;
          b_mem[i][j] <= '0;
        end
      step   <= '0;
      result <= '0;
    end else begin
      if (is_load) begin
        if (ins.sel) b_mem[ins.row][ins.col] <= ins.data;
        else a_mem[ins.row][ins.col] <= ins.data;
        step <= '0;
      end
      if (is_run && step != 4'(RUN_STEPS)) step <= step + 4'd1;
      if (ins.op == OP_STORE) result <= store_byte;
    end
  end

  genvar r, c;
  generate
    for (r = 0; r < DIM; r++) begin : g_edge
      assign a_h[r][0] = a_edge[r];
      assign b_v[0][r] = b_edge[r];
    end
    for (r = 0; r < DIM; r++) begin : g_row
      for (c = 0; c < DIM; c++) begin : g_col
        tpu_pe u_pe (
          .clk   (clk),
          .rst   (rst),
          .clear (is_load),
          .en    (is_run),
          .a_in  (a_h[r][c]),
          .b_in  (b_v[r][c]),
          .a_out (a_h[r][c+1]),
          .b_out (b_v[r+1][c]),
          .acc   (acc[r][c])
        );
      end
    end
  endgenerate
endmodule

// File: tb/tb_mini_tpu.sv
// tb_mini_tpu: directed checks of mini_tpu against hand values and a matmul model
module tb_mini_tpu;
  localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, LOAD = 2'b10, STORE = 2'b11;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instruction;
  logic [7:0]  result;
  int total = 0;
  int bad = 0;
  int am [16];
  int bm [16];
  logic [7:0] held;

  mini_tpu dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .result      (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] word(input logic [1:0] op, input logic sel, input int r, input int c, input int d);
    return {1'b0, op, sel, 2'(r), 2'(c), 8'(d)};
  endfunction

  task automatic issue(input logic [15:0] w);
    @(negedge clk);
    instruction = w;
    @(posedge clk);
    #1;
  endtask

  task automatic runs(input int n);
    repeat (n) issue(word(RUN, 1'b0, 0, 0, 0));
  endtask

  task automatic store(input int r, input int c);
    issue(word(STORE, 1'b0, r, c, 8'hA5));
  endtask

  task automatic load_all();
    for (int k = 0; k < 16; k++) issue(word(LOAD, 1'b0, k / 4, k % 4, am[k]));
    for (int k = 0; k < 16; k++) issue(word(LOAD, 1'b1, k / 4, k % 4, bm[k]));
  endtask

  function automatic int cval(input int r, input int c);
    int s = 0;
    for (int k = 0; k < 4; k++) s += am[r*4+k] * bm[k*4+c];
    return s % 65536;
  endfunction

  function automatic logic [7:0] byte_of(input int v);
`ifdef TPU_SATURATE_EN
    return (v > 255) ? 8'hFF : 8'(v);
`else
    return 8'(v);
`endif
  endfunction

  task automatic check_all(input string tag);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        store(r, c);
        check($sformatf("%s[%0d][%0d]", tag, r, c), result, byte_of(cval(r, c)));
      end
  endtask

  task automatic set_dense();
    for (int k = 0; k < 16; k++) begin
      am[k] = k + 1;
      bm[k] = k + 1;
    end
  endtask

  initial begin
    rst = 1'b1;
    instruction = word(STORE, 1'b0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", result, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    store(0, 0);
    check("rst_c00", result, 8'h00);
    store(3, 3);
    check("rst_c33", result, 8'h00);

    for (int k = 0; k < 16; k++) begin
      am[k] = k + 1;
      bm[k] = (k / 4 == k % 4) ? 1 : 0;
    end
    load_all();
    runs(10);
    for (int k = 0; k < 16; k++) begin
      store(k / 4, k % 4);
      check($sformatf("ident[%0d]", k), result, 8'(k + 1));
    end

    set_dense();
    load_all();
    runs(10);
    store(0, 0);
    check("dense_c00", result, 8'h5A);
    store(3, 3);
`ifdef TPU_SATURATE_EN
    check("dense_c33", result, 8'hFF);
`else
    check("dense_c33", result, 8'h58);
`endif
    check_all("dense");

    load_all();
    runs(1);
    store(0, 0);
    check("part1_c00", result, 8'h01);
    store(0, 1);
    check("part1_c01", result, 8'h00);
    runs(9);
    store(0, 0);
    check("part10_c00", result, 8'h5A);
    runs(5);
    store(0, 0);
    check("part15_c00", result, 8'h5A);
    check_all("sat_steps");

    load_all();
    for (int s = 0; s < 10; s++) begin
      runs(1);
      issue(word(NOP, 1'b1, 3, 3, 8'hFF));
      store(s % 4, 0);
    end
    check_all("ilv");
    store(0, 0);
    held = result;
    check("hold_store", held, 8'h5A);
    issue(word(NOP, 1'b0, 1, 1, 0));
    check("hold_nop", result, 8'h5A);
    runs(2);
    check("hold_run", result, 8'h5A);
    issue(word(LOAD, 1'b0, 0, 0, 1));
    check("hold_load", result, 8'h5A);

    set_dense();
    load_all();
    runs(5);
    @(negedge clk);
    rst = 1'b1;
    instruction = word(LOAD, 1'b0, 0, 0, 8'h77);
    @(posedge clk);
    #1;
    check("rstmid_result", result, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      am[k] = 0;
      bm[k] = 0;
    end
    runs(10);
    check_all("rstmid_zero");
    for (int k = 0; k < 16; k++) begin
      am[k] = 2;
      bm[k] = 3;
    end
    load_all();
    runs(10);
    store(2, 1);
    check("reload_c21", result, 8'h18);
    check_all("reload");

    set_dense();
    load_all();
    runs(5);
    issue(word(LOAD, 1'b0, 0, 0, 1));
    runs(10);
    store(0, 0);
    check("reld_c00", result, 8'h5A);
    check_all("reld");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
